// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera key-to-SCCB configuration scheduler.
package cam_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PICK = 2'd1,
        ST_REQ  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int unsigned KEY_N = 4;
    localparam int unsigned LVL_W = 4;

    localparam logic [1:0] KEY_UP    = 2'd0;
    localparam logic [1:0] KEY_DOWN  = 2'd1;
    localparam logic [1:0] KEY_LEFT  = 2'd2;
    localparam logic [1:0] KEY_RIGHT = 2'd3;

    localparam int unsigned LEVEL_MAX_DEF   = 8;
    localparam logic [15:0] BRIGHT_ADDR_DEF = 16'h5587;
    localparam logic [15:0] CONTR_ADDR_DEF  = 16'h5586;

endpackage

// File: rtl/key_cam_cfg_sched_rr_arb4.sv
// Four-request round-robin arbiter; lowest offset from ptr wins. Purely combinational.
module rr_arb4
    import cam_cfg_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] grant_idx,
    output logic       grant_vld
);

    logic [1:0] idx;

    // Scan from farthest to nearest offset so the nearest requester is written last.
    always_comb begin
        grant_idx = 2'd0;
        grant_vld = 1'b0;
        idx       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                grant_idx = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_cam_cfg_sched.sv
// Turns key pulses into brightness/contrast level steps and sequences one
// SCCB register write per accepted step, with ack timeout and inter-write gap.
module key_cam_cfg_sched
    import cam_cfg_pkg::*;
#(
    parameter int unsigned LEVEL_MAX   = LEVEL_MAX_DEF,
    parameter int unsigned LEVEL_RST   = 4,
    parameter logic [15:0] BRIGHT_ADDR = BRIGHT_ADDR_DEF,
    parameter logic [15:0] CONTR_ADDR  = CONTR_ADDR_DEF,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned GAP_CYC     = 5000
) (
    input  logic             Clk_50mhz,
    input  logic             Rst,
    input  logic             Key_up,
    input  logic             Key_down,
    input  logic             Key_left,
    input  logic             Key_right,
    output logic             Wr_req,
    output logic [15:0]      Wr_addr,
    output logic [7:0]       Wr_data,
    input  logic             Wr_ack,
    output logic             Busy,
    output logic             Err,
    output logic [LVL_W-1:0] Bright_lvl,
    output logic [LVL_W-1:0] Contr_lvl
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e             state_q, state_d;
    logic [KEY_N-1:0]   pend_q, pend_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_req_q, wr_req_d;
    logic [15:0]        wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [LVL_W-1:0]   bright_q, bright_d;
    logic [LVL_W-1:0]   contr_q, contr_d;
    logic [LVL_W-1:0]   tgt_q, tgt_d;
    logic               sel_bright_q, sel_bright_d;

    logic [1:0]         grant_idx;
    logic               grant_vld;
    logic [KEY_N-1:0]   key_set;
    logic [KEY_N-1:0]   key_clr;
    logic               is_bright;
    logic               is_inc;
    logic [LVL_W-1:0]   cur_lvl;
    logic [LVL_W-1:0]   step_tgt;
    logic               step_ok;
    logic               req_last;
    logic               gap_last;

    rr_arb4 u_arb (
        .req       (pend_q),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign key_set  = {Key_right, Key_left, Key_down, Key_up};
    assign req_last = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign gap_last = (cnt_q == CNT_W'(GAP_CYC - 1));

    // Step decode for the granted key: target level and whether it stays in range.
    always_comb begin
        is_bright = (grant_idx == KEY_UP) || (grant_idx == KEY_DOWN);
        is_inc    = (grant_idx == KEY_UP) || (grant_idx == KEY_RIGHT);
        cur_lvl   = is_bright ? bright_q : contr_q;
        if (is_inc) begin
            step_ok  = (cur_lvl < LVL_W'(LEVEL_MAX));
            step_tgt = cur_lvl + LVL_W'(1);
        end else begin
            step_ok  = (cur_lvl != '0);
            step_tgt = cur_lvl - LVL_W'(1);
        end
    end

    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            ptr_q        <= KEY_UP;
            cnt_q        <= '0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            bright_q     <= LVL_W'(LEVEL_RST);
            contr_q      <= LVL_W'(LEVEL_RST);
            tgt_q        <= '0;
            sel_bright_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            wr_req_q     <= wr_req_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            bright_q     <= bright_d;
            contr_q      <= contr_d;
            tgt_q        <= tgt_d;
            sel_bright_q <= sel_bright_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pend_q != '0) state_d = ST_PICK;
            ST_PICK: state_d = (grant_vld && step_ok) ? ST_REQ : ST_IDLE;
            ST_REQ:  if (Wr_ack || req_last) state_d = ST_GAP;
            ST_GAP:  if (gap_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; a new key pulse always wins over the PICK clear.
    always_comb begin
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_d        = err_q;
        bright_d     = bright_q;
        contr_d      = contr_q;
        tgt_d        = tgt_q;
        sel_bright_d = sel_bright_q;
        key_clr      = '0;

        unique case (state_q)
            ST_PICK: begin
                if (grant_vld) begin
                    key_clr = KEY_N'(1) << grant_idx;
                    ptr_d   = grant_idx + 2'd1;
                    if (step_ok) begin
                        wr_req_d     = 1'b1;
                        wr_addr_d    = is_bright ? BRIGHT_ADDR : CONTR_ADDR;
                        wr_data_d    = {step_tgt, 4'h0};
                        tgt_d        = step_tgt;
                        sel_bright_d = is_bright;
                        cnt_d        = '0;
                    end
                end
            end
            ST_REQ: begin
                if (Wr_ack) begin
                    wr_req_d = 1'b0;
                    cnt_d    = '0;
                    if (sel_bright_q) bright_d = tgt_q;
                    else              contr_d  = tgt_q;
                end else if (req_last) begin
                    wr_req_d = 1'b0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: cnt_d = gap_last ? '0 : cnt_q + CNT_W'(1);
            default: ;
        endcase

        pend_d = (pend_q & ~key_clr) | key_set;
        busy_d = (state_d != ST_IDLE);
    end

    assign Wr_req     = wr_req_q;
    assign Wr_addr    = wr_addr_q;
    assign Wr_data    = wr_data_q;
    assign Busy       = busy_q;
    assign Err        = err_q;
    assign Bright_lvl = bright_q;
    assign Contr_lvl  = contr_q;

endmodule

// File: doc/key_cam_cfg_sched.md
Name: key_cam_cfg_sched

Overview:
- Sits between the debounced key-pulse block and the SCCB write master in the OV5640 VGA capture design.
- Latches single-cycle key pulses (up/down/left/right) into pending flags and services them round-robin.
- Steps brightness (Up/Down) or contrast (Left/Right) levels, then sequences one SCCB register write per accepted step.
- Uses a req/ack handshake with timeout and an inter-write gap.

Parameters:
- LEVEL_MAX, 8, top saturating level; levels span 0..LEVEL_MAX.
- LEVEL_RST, 4, level loaded at reset for both brightness and contrast.
- BRIGHT_ADDR, 16'h5587, SCCB register address for brightness.
- CONTR_ADDR, 16'h5586, SCCB register address for contrast.
- TIMEOUT_CYC, 100000, maximum cycles to wait for Wr_ack.
- GAP_CYC, 5000, idle cycles enforced after each ack or timeout.

Ports:
- Clk_50mhz  in  1  system clock.
- Rst  in  1  asynchronous, active-high reset.
- Key_up  in  1  single-cycle pulse: brightness +1.
- Key_down  in  1  single-cycle pulse: brightness -1.
- Key_left  in  1  single-cycle pulse: contrast -1.
- Key_right  in  1  single-cycle pulse: contrast +1.
- Wr_req  out  1  write request to the SCCB master.
- Wr_addr  out  16  register address, valid while Wr_req is high.
- Wr_data  out  8  register data, valid while Wr_req is high.
- Wr_ack  in  1  single-cycle completion pulse from the SCCB master.
- Busy  out  1  high whenever state is not IDLE.
- Err  out  1  sticky timeout flag; cleared only by Rst.
- Bright_lvl  out  4  committed brightness level.
- Contr_lvl  out  4  committed contrast level.

Behaviour:
- Reset state: Wr_req=0, Wr_addr=0, Wr_data=0, Busy=0, Err=0, Bright_lvl=Contr_lvl=LEVEL_RST, pending=4'b0000, RR pointer=0 (Up), state=IDLE.
- Pending flags:
  - Index order is 0=Up, 1=Down, 2=Left, 3=Right.
  - A key pulse sets its flag on the same edge.
  - A pulse on an already-pending key merges into that flag (one step only).
  - If set and clear coincide on the same edge, set wins.
- Arbitration:
  - Round-robin starting at the RR pointer.
  - After granting index k, the pointer becomes (k+1) mod 4.
- State machine IDLE -> PICK -> REQ -> GAP -> IDLE:
  - IDLE: if any pending flag is set, go to PICK.
  - PICK (1 cycle):
    - Grant one key and clear its pending flag.
    - Compute target = committed level ±1.
    - If the target is outside 0..LEVEL_MAX, the step is dropped: no write, return to IDLE.
    - Otherwise latch Wr_addr, Wr_data = {target[3:0], 4'h0} (zero-extended to 8 bits; level 8 gives 8'h80) and go to REQ.
  - REQ:
    - Wr_req=1; Wr_addr and Wr_data stay stable.
    - On Wr_ack: commit target to Bright_lvl/Contr_lvl, drop Wr_req on the next edge, go to GAP.
    - If the timeout counter reaches TIMEOUT_CYC-1 without ack: drop Wr_req, set Err, do not commit the level, go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Latency: a key pulse high in cycle N with the block IDLE gives Wr_req high from cycle N+3.
- Pulses arriving while Busy are held in the pending flags. A pulse on the key being serviced, arriving at or after PICK, is queued for a further step.
- Wr_ack outside REQ is ignored.
- Rst asserted mid-transaction returns everything to reset values immediately (Wr_req drops asynchronously).
- Counters are wide enough for the max of TIMEOUT_CYC and GAP_CYC (17 bits at defaults); no wrap-around.

Decomposition:
- Shared package cam_cfg_pkg holds:
  - state encoding (IDLE, PICK, REQ, GAP);
  - key index constants;
  - default register addresses;
  - LEVEL_MAX.
- One sub-module, rr_arb4: 4-request round-robin arbiter.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: grant_idx[1:0], grant_vld.
  - Purely combinational.
  - The pointer register lives in the parent.

Test Plan:
- Release Rst with no stimulus -> all outputs at reset values, Bright_lvl=Contr_lvl=4, Busy=0, Wr_req=0.
- Key_up pulse at cycle N -> Wr_req=1 at N+3 with Wr_addr=16'h5587 and Wr_data=8'h50. Ack after 10 cycles -> Bright_lvl=5, Wr_req=0 next cycle, Busy=1 for GAP_CYC more cycles.
- Key_up and Key_left pulsed in the same cycle (pointer=0) -> two writes in order: brightness 8'h50 first, then contrast (addr 16'h5586, data 8'h30); pointer ends at 3.
- Five Key_up pulses from level 4, each acked -> four writes reaching data 8'h80 and Bright_lvl=8; the fifth is dropped with no Wr_req.
- Key_right pulse with Wr_ack never returned -> Wr_req deasserts after TIMEOUT_CYC cycles, Err=1, Contr_lvl stays 4.
- Three Key_down pulses during one REQ -> merged into a single pending step; exactly one further write (8'h20) follows the gap.
- Rst asserted while Wr_req=1 -> Wr_req=0 immediately, pending cleared, levels back to 4.
